// File: rtl/afe_spi_pkg.sv
// Shared definitions for the AFE SPI arbiter: FSM states, requester ids,
// default link geometry and a counter-width helper.
// Optional feature macro used by the design: AFE_SPI_READBACK_EN (MISO capture).
package afe_spi_pkg;

    // Default link geometry
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_LATCH_CYC = 2;

    // Requester identifiers, also the value reported on rsp_id
    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_LOC  = 1'b1;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bits needed for a counter running 0..n-1 (never less than one bit)
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/afe_spi_shifter.sv
// SPI word engine: clock divider, half-period counter and the MOSI/MISO shift
// registers. A load pulse parks the word so its MSB is on MOSI before the
// first clock; a start pulse runs 2*DATA_W half-periods beginning with a
// rising spi_clk. MISO is captured on every rising edge, MOSI advances on every
// falling edge. 'last' flags the final cycle of the shift phase.
// Optional feature macro: AFE_SPI_READBACK_EN. When undefined there is no MISO
// capture logic and rx_data is constant zero.
module afe_spi_shifter
    import afe_spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              last,
    output logic              spi_clk,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data
);

    localparam int DIV_W  = cnt_width(CLK_DIV);
    localparam int HALF_W = cnt_width(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    logic              active_r;
    logic [DIV_W-1:0]  div_r;
    logic [HALF_W-1:0] half_r;
    logic              clk_r;
    logic [DATA_W-1:0] tx_r;
    logic              edge_s;
    logic              rise_s;
    logic              fall_s;

    // Decode the end of a half-period: either an spi_clk toggle or end of word
    always_comb begin
        edge_s = 1'b0;
        last   = 1'b0;
        if (active_r && (div_r == DIV_LAST)) begin
            if (half_r == HALF_LAST) begin
                last   = 1'b1;
                edge_s = 1'b0;
            end else begin
                last   = 1'b0;
                edge_s = 1'b1;
            end
        end else begin
            last   = 1'b0;
            edge_s = 1'b0;
        end
    end

    assign rise_s  = edge_s && !clk_r;
    assign fall_s  = edge_s && clk_r;
    assign spi_clk = clk_r;
    assign mosi    = tx_r[DATA_W-1];

    // Divider, half-period counter and the registered spi_clk level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            div_r    <= '0;
            half_r   <= '0;
            clk_r    <= 1'b0;
        end else if (start) begin
            active_r <= 1'b1;
            div_r    <= '0;
            half_r   <= '0;
            clk_r    <= 1'b1;
        end else if (active_r) begin
            if (div_r == DIV_LAST) begin
                div_r <= '0;
                if (half_r == HALF_LAST) begin
                    active_r <= 1'b0;
                    clk_r    <= 1'b0;
                end else begin
                    half_r <= half_r + 1'b1;
                    clk_r  <= ~clk_r;
                end
            end else begin
                div_r <= div_r + 1'b1;
            end
        end
    end

    // MOSI shift register: loaded on accept, zero-filled on each falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r <= '0;
        end else if (load) begin
            tx_r <= load_data;
        end else if (fall_s) begin
            tx_r <= {tx_r[DATA_W-2:0], 1'b0};
        end
    end

`ifdef AFE_SPI_READBACK_EN
    logic [DATA_W-1:0] rx_r;

    // MISO capture on the start edge and every later rising spi_clk edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r <= '0;
        end else if (start || rise_s) begin
            rx_r <= {rx_r[DATA_W-2:0], miso};
        end
    end

    assign rx_data = rx_r;
`else
    logic unused_rx_s;

    assign unused_rx_s = miso ^ rise_s;
    assign rx_data     = '0;
`endif

endmodule

// File: rtl/afe_spi_arbiter.sv
// Round-robin owner of the single SPI AFE link. Host and local requesters
// compete in IDLE; the winner's word is sent MSB-first, latched with a spi_sel
// pulse and answered with one rsp_valid pulse. Sequence per command:
// IDLE -> SETUP -> SHIFT -> LATCH -> DONE -> IDLE.
// Optional feature macro: AFE_SPI_READBACK_EN (MISO readback into rsp_data,
// otherwise rsp_data stays zero; timing is identical either way).
module afe_spi_arbiter
    import afe_spi_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LATCH_CYC = DEF_LATCH_CYC
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [DATA_W-1:0] host_req_data,
    input  logic [1:0]        host_req_sel,
    input  logic              loc_req_valid,
    output logic              loc_req_ready,
    input  logic [DATA_W-1:0] loc_req_data,
    input  logic [1:0]        loc_req_sel,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_sel,
    output logic              sel0,
    output logic              sel1
);

    localparam int CNT_MAX = (CLK_DIV > LATCH_CYC) ? CLK_DIV : LATCH_CYC;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);

    state_t            state_r;
    logic              en_r;
    logic              last_id_r;
    logic              id_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sel0_r;
    logic              sel1_r;
    logic              spi_sel_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              busy_r;

    logic              host_ready_s;
    logic              loc_ready_s;
    logic              accept_s;
    logic              grant_id_s;
    logic [DATA_W-1:0] grant_data_s;
    logic [1:0]        grant_sel_s;
    logic              start_s;
    logic              shift_last_s;
    logic [DATA_W-1:0] rx_data_s;

    // Round-robin grant: only in IDLE, and not in the first cycle out of reset
    // so that ready is guaranteed low while the reset is still applied
    always_comb begin
        host_ready_s = 1'b0;
        loc_ready_s  = 1'b0;
        if ((state_r == ST_IDLE) && en_r) begin
            if (host_req_valid && loc_req_valid) begin
                if (last_id_r == REQ_HOST) begin
                    loc_ready_s = 1'b1;
                end else begin
                    host_ready_s = 1'b1;
                end
            end else begin
                host_ready_s = host_req_valid;
                loc_ready_s  = loc_req_valid;
            end
        end else begin
            host_ready_s = 1'b0;
            loc_ready_s  = 1'b0;
        end
    end

    // Mux the granted requester's command fields
    always_comb begin
        grant_id_s   = REQ_HOST;
        grant_data_s = host_req_data;
        grant_sel_s  = host_req_sel;
        if (loc_ready_s) begin
            grant_id_s   = REQ_LOC;
            grant_data_s = loc_req_data;
            grant_sel_s  = loc_req_sel;
        end else begin
            grant_id_s   = REQ_HOST;
            grant_data_s = host_req_data;
            grant_sel_s  = host_req_sel;
        end
    end

    assign accept_s = host_ready_s || loc_ready_s;
    assign start_s  = (state_r == ST_SETUP) && (cnt_r == SETUP_LAST);

    afe_spi_shifter #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .load      (accept_s),
        .load_data (grant_data_s),
        .start     (start_s),
        .last      (shift_last_s),
        .spi_clk   (spi_clk_o),
        .mosi      (spi_mosi_o),
        .miso      (spi_miso_i),
        .rx_data   (rx_data_s)
    );

    // Transfer FSM with registered select, latch strobe and response outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_IDLE;
            en_r        <= 1'b0;
            last_id_r   <= REQ_LOC;
            id_r        <= REQ_HOST;
            cnt_r       <= '0;
            sel0_r      <= 1'b0;
            sel1_r      <= 1'b0;
            spi_sel_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            en_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_SETUP;
                        cnt_r     <= '0;
                        id_r      <= grant_id_s;
                        last_id_r <= grant_id_s;
                        sel0_r    <= grant_sel_s[0];
                        sel1_r    <= grant_sel_s[1];
                        busy_r    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last_s) begin
                        state_r   <= ST_LATCH;
                        spi_sel_r <= 1'b1;
                        cnt_r     <= '0;
                    end
                end
                ST_LATCH: begin
                    if (cnt_r == LATCH_LAST) begin
                        state_r     <= ST_DONE;
                        spi_sel_r   <= 1'b0;
                        sel0_r      <= 1'b0;
                        sel1_r      <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_data_r  <= rx_data_s;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    sel0_r      <= 1'b0;
                    sel1_r      <= 1'b0;
                    spi_sel_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign host_req_ready = host_ready_s;
    assign loc_req_ready  = loc_ready_s;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_id         = rsp_id_r;
    assign rsp_data       = rsp_data_r;
    assign busy           = busy_r || accept_s;
    assign spi_sel        = spi_sel_r;
    assign sel0           = sel0_r;
    assign sel1           = sel1_r;

endmodule
